// File: rtl/vsddeserializer_v1.sv
// rtl/vsddeserializer_v1.sv - comma-aligned serial-to-parallel word receiver
`timescale 1ns/1ps

module vsddeserializer_v1 #(
    parameter int               WIDTH      = 10,
    parameter logic [WIDTH-1:0] COMMA      = 10'b0011111010,
    parameter int               LOCK_COUNT = 3,
    parameter int               LOSS_COUNT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             serial_in,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             is_comma,
    output logic             locked,
    output logic             align_err
);

    localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int GW = (LOCK_COUNT > 0) ? $clog2(LOCK_COUNT + 1) : 1;
    localparam int MW = (LOSS_COUNT > 0) ? $clog2(LOSS_COUNT + 1) : 1;

    localparam logic [PW-1:0] PHASE_LAST = PW'(WIDTH - 1);
    localparam logic [GW-1:0] GOOD_TGT   = GW'(LOCK_COUNT);
    localparam logic [MW-1:0] MISS_TGT   = MW'(LOSS_COUNT);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] win;
    logic [PW-1:0]    phase_q, phase_d;
    logic [GW-1:0]    good_q, good_d;
    logic [MW-1:0]    miss_q, miss_d;
    logic [WIDTH-1:0] dout_d;
    logic             dv_d, ic_d, ae_d, locked_d;
    logic             comma_hit, boundary;

    // The window is a comma in either polarity.
    assign comma_hit = (win == COMMA) || (win == ~COMMA);
    // A complete word occupies the window when the phase counter sits on its last slot.
    assign boundary  = (phase_q == PHASE_LAST);

    // Shift the serial stream into the window, earliest bit ending up in the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win <= '0;
        end else begin
            win <= {win[WIDTH-2:0], serial_in};
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_HUNT;
            phase_q    <= '0;
            good_q     <= '0;
            miss_q     <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            is_comma   <= 1'b0;
            align_err  <= 1'b0;
            locked     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            good_q     <= good_d;
            miss_q     <= miss_d;
            data_out   <= dout_d;
            data_valid <= dv_d;
            is_comma   <= ic_d;
            align_err  <= ae_d;
            locked     <= locked_d;
        end
    end

    // Alignment FSM: hunt for a comma, verify it repeats on the boundary, then track it.
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        miss_d  = miss_q;
        phase_d = boundary ? '0 : (phase_q + PW'(1));
        dout_d  = data_out;
        dv_d    = 1'b0;
        ic_d    = 1'b0;
        ae_d    = 1'b0;

        case (state_q)
            ST_HUNT: begin
                if (comma_hit) begin
                    // The comma just filled the window; the next word completes WIDTH edges later.
                    phase_d = '0;
                    good_d  = GW'(1);
                    if (LOCK_COUNT <= 1) begin
                        state_d = ST_LOCKED;
                    end else begin
                        state_d = ST_VERIFY;
                    end
                end
            end

            ST_VERIFY: begin
                if (comma_hit) begin
                    if (boundary) begin
                        if (good_q < GOOD_TGT) begin
                            good_d = good_q + GW'(1);
                        end
                        if (good_q >= GOOD_TGT - GW'(1)) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        // A comma on a different alignment wins; restart the count there.
                        phase_d = '0;
                        good_d  = GW'(1);
                    end
                end
            end

            ST_LOCKED: begin
                if (boundary) begin
                    dout_d = win;
                    dv_d   = 1'b1;
                    ic_d   = comma_hit;
                    if (comma_hit) begin
                        miss_d = '0;
                    end
                end else if (comma_hit) begin
                    // Misplaced comma: flag it but keep the current alignment.
                    ae_d = 1'b1;
                    if (miss_q < MISS_TGT) begin
                        miss_d = miss_q + MW'(1);
                    end
                    if (miss_q >= MISS_TGT - MW'(1)) begin
                        state_d = ST_HUNT;
                        miss_d  = '0;
                        good_d  = '0;
                    end
                end
            end

            default: begin
                state_d = ST_HUNT;
                good_d  = '0;
                miss_d  = '0;
            end
        endcase

        locked_d = (state_d == ST_LOCKED);
    end

endmodule
